boa_pmu: RTL and testbench
==========================

# boa_pmu

Power-management unit: the driving end of the PMU bus. CPU software requests a system reset or power-off through a small memory-mapped register file. The block drives `pmu_rst` / `pmu_shdn` after a programmable cycle delay, and the top level turns these into the system reset or simulator exit. An optional watchdog forces a reset when software stops kicking it.

## Interface
- `KEY`, default 16'h5AFE: unlock key required in bits 31:16 of CTRL and WDT_KICK writes.
- `DELAY_W`, default 16: width of the DELAY register and of the countdown.
- `clk`  in  1: system clock.
- `rst`  in  1: asynchronous, active-high reset; clears all state.
- `we`  in  1: register write strobe.
- `re`  in  1: register read strobe.
- `addr`  in  3: word address, byte address bits 4:2.
- `wdata`  in  32: write data.
- `rdata`  out  32: read data, registered.
- `ready`  out  1: constant 1; every access completes in one cycle.
- `pmu_rst`  out  1: reset request, wired to `pmu_bus.rst`.
- `pmu_shdn`  out  1: power-off request, wired to `pmu_bus.shdn`.

## Operation
- Registers, by word address:
  - 0 CTRL, write-only. Bits 31:16 = key; bits 1:0 = command: 00 abort, 01 reset, 10 shutdown, 11 watchdog enable.
  - 1 DELAY, read/write; `DELAY_W` bits, zero-extended on read.
  - 2 STATUS, read-only. Bits 1:0 = state; bit 2 = key error (sticky); bit 3 = watchdog enabled; bit 4 = watchdog fired.
  - 3 WDT_LOAD, read/write, 32 bits.
  - 4 WDT_KICK, write-only; requires the key.
  - Addresses 5–7 read 0; writes to them are ignored.
- States: IDLE=0, COUNT=1, RESET=2, SHUTDOWN=3.
- Transitions:
  - IDLE + valid reset/shutdown command → COUNT. Counter loads DELAY; the pending command is latched.
  - COUNT, counter==0 → RESET or SHUTDOWN, per the latched command. Otherwise the counter decrements each cycle.
  - COUNT + valid abort → IDLE.
  - COUNT + other valid command → ignored; the first request wins.
  - RESET and SHUTDOWN are terminal until `rst`.
- Output decode is registered:
  - `pmu_rst` = 1 exactly in RESET.
  - `pmu_shdn` = 1 exactly in SHUTDOWN.
  - They are never high together.
- A CTRL or WDT_KICK write with the wrong key:
  - sets STATUS bit 2 and has no other effect;
  - bit 2 clears only on `rst`.
- Abort in IDLE: no-op; does not set the error bit.
- A DELAY write during COUNT does not affect the running count; it applies to the next request.

## Timing
- Reset values: `rdata`=0, `pmu_rst`=0, `pmu_shdn`=0, state IDLE, DELAY=0, WDT_LOAD=0, all flags 0.
- Command write accepted on edge N with DELAY=D: state is COUNT in cycle N+1, and the output is high from cycle N+2+D.
- With D=0, the output is high from cycle N+2.
- Read: `re` in cycle N → `rdata` valid in cycle N+1. Otherwise `rdata` holds its last value.
- Counter arithmetic is unsigned `DELAY_W`; max delay = 2^DELAY_W−1, with no wrap.
- Simultaneous watchdog expiry and a CTRL command in the same cycle: watchdog wins.
- `rst` asserted mid-COUNT: immediate return to reset values; the request is lost.

## Configuration
- `BOA_PMU_WDT_EN` defined:
  - Command 11 loads the watchdog counter from WDT_LOAD and sets enable. Enable cannot be cleared except by `rst`.
  - A keyed WDT_KICK write reloads the counter from WDT_LOAD.
  - The counter decrements each cycle in IDLE and COUNT.
  - Expiry (counter==0 while enabled) → RESET next cycle, bypassing DELAY, and sets STATUS bit 4.
- Undefined:
  - Command 11 is treated as an invalid command and sets the error bit.
  - WDT_LOAD and WDT_KICK read 0; writes to them are ignored.
  - STATUS bits 3 and 4 read 0.

## Structure
- Shared package `boa_pmu_pkg`: state enum, command enum, register address constants, STATUS bit positions, default key.
- One sub-module, `boa_pmu_wdt`: the watchdog counter with load/kick/expire. Instantiated only under `BOA_PMU_WDT_EN`.

## Test plan
- Write CTRL=0x5AFE0001 with DELAY=0 → `pmu_rst` high 2 cycles after the write edge; STATUS reads state 2.
- Write DELAY=10, then CTRL=0x5AFE0002 → `pmu_shdn` rises exactly 12 cycles after the CTRL write edge; `pmu_rst` stays 0.
- Write DELAY=100 and a reset command; after 20 cycles write CTRL=0x5AFE0000 → state IDLE, no output ever asserts.
- Write CTRL=0x12340001 → no state change; STATUS bit 2 = 1; bit 2 clears only after `rst`.
- WDT enabled, WDT_LOAD=50: kick every 40 cycles for 500 cycles → no reset. Then stop kicking → `pmu_rst` high 52 cycles after the last kick; STATUS bit 4 = 1.
- Assert `rst` in COUNT with 5 cycles left → outputs stay 0; all registers read their reset values.

Source files
------------

// File: rtl/boa_pmu_pkg.sv
// Shared types and constants for the boa_pmu power-management unit.
package boa_pmu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COUNT = 2'd1,
    ST_RESET = 2'd2,
    ST_SHDN  = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    CMD_ABORT = 2'd0,
    CMD_RESET = 2'd1,
    CMD_SHDN  = 2'd2,
    CMD_WDT   = 2'd3
  } cmd_e;

  localparam logic [2:0] ADDR_CTRL     = 3'd0;
  localparam logic [2:0] ADDR_DELAY    = 3'd1;
  localparam logic [2:0] ADDR_STATUS   = 3'd2;
  localparam logic [2:0] ADDR_WDT_LOAD = 3'd3;
  localparam logic [2:0] ADDR_WDT_KICK = 3'd4;

  localparam int STAT_KEY_ERR   = 2;
  localparam int STAT_WDT_EN    = 3;
  localparam int STAT_WDT_FIRED = 4;

  localparam logic [15:0] KEY_DEFAULT = 16'h5AFE;

endpackage

// File: rtl/boa_pmu_wdt.sv
// Watchdog counter: load arms and enables, kick reloads, expire when armed and at zero.
module boa_pmu_wdt (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        kick,
  input  logic        run,
  input  logic [31:0] load_val,
  output logic        en,
  output logic        expire
);

  logic [31:0] cnt;

  // Counter saturates at zero; expiry stays asserted until rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en  <= 1'b0;
      cnt <= '0;
    end else begin
      if (load) begin
        en  <= 1'b1;
        cnt <= load_val;
      end else if (kick) begin
        cnt <= load_val;
      end else if (en && run && cnt != '0) begin
        cnt <= cnt - 32'd1;
      end
    end
  end

  assign expire = en && (cnt == '0);

endmodule

// File: rtl/boa_pmu.sv
// PMU bus driver: keyed register file that requests reset/power-off after a delay.
// Optional watchdog built when BOA_PMU_WDT_EN is defined.
import boa_pmu_pkg::*;

module boa_pmu #(
  parameter logic [15:0] KEY     = KEY_DEFAULT,
  parameter int          DELAY_W = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic        re,
  input  logic [2:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        pmu_rst,
  output logic        pmu_shdn
);

  state_e               state;
  logic [DELAY_W-1:0]   cnt;
  logic [DELAY_W-1:0]   delay;
  logic                 pend_shdn;
  logic                 key_err;
  logic                 wdt_en;
  logic                 wdt_expire;
  logic                 wdt_fired;
  logic                 key_ok, ctrl_wr, kick_wr, cmd_valid, key_err_set, run;
  cmd_e                 cmd;
  logic [31:0]          status, delay_ext;

  assign ready   = 1'b1;
  assign key_ok  = (wdata[31:16] == KEY);
  assign ctrl_wr = we && (addr == ADDR_CTRL);
  assign kick_wr = we && (addr == ADDR_WDT_KICK);
  assign cmd     = cmd_e'(wdata[1:0]);
  assign run     = (state == ST_IDLE) || (state == ST_COUNT);

`ifdef BOA_PMU_WDT_EN
  logic [31:0] wdt_load;

  assign cmd_valid   = ctrl_wr && key_ok;
  assign key_err_set = (ctrl_wr || kick_wr) && !key_ok;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wdt_load  <= '0;
      wdt_fired <= 1'b0;
    end else begin
      if (we && addr == ADDR_WDT_LOAD) wdt_load <= wdata;
      if (wdt_expire && run) wdt_fired <= 1'b1;
    end
  end

  boa_pmu_wdt u_wdt (
    .clk      (clk),
    .rst      (rst),
    .load     (cmd_valid && cmd == CMD_WDT && run),
    .kick     (kick_wr && key_ok),
    .run      (run),
    .load_val (wdt_load),
    .en       (wdt_en),
    .expire   (wdt_expire)
  );
`else
  // Without the watchdog, command 11 is simply an invalid command.
  assign cmd_valid   = ctrl_wr && key_ok && (cmd != CMD_WDT);
  assign key_err_set = ctrl_wr && (!key_ok || cmd == CMD_WDT);
  assign wdt_en      = 1'b0;
  assign wdt_expire  = 1'b0;
  assign wdt_fired   = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      delay     <= '0;
      pend_shdn <= 1'b0;
      key_err   <= 1'b0;
      pmu_rst   <= 1'b0;
      pmu_shdn  <= 1'b0;
    end else begin
      pmu_rst  <= (state == ST_RESET);
      pmu_shdn <= (state == ST_SHDN);
      if (key_err_set) key_err <= 1'b1;
      if (we && addr == ADDR_DELAY) delay <= wdata[DELAY_W-1:0];
      // Watchdog expiry outranks any command arriving in the same cycle.
      case (state)
        ST_IDLE: begin
          if (wdt_expire) state <= ST_RESET;
          else if (cmd_valid && (cmd == CMD_RESET || cmd == CMD_SHDN)) begin
            state     <= ST_COUNT;
            cnt       <= delay;
            pend_shdn <= (cmd == CMD_SHDN);
          end
        end
        ST_COUNT: begin
          if (wdt_expire)                         state <= ST_RESET;
          else if (cmd_valid && cmd == CMD_ABORT) state <= ST_IDLE;
          else if (cnt == '0)                     state <= pend_shdn ? ST_SHDN : ST_RESET;
          else                                    cnt   <= cnt - 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    delay_ext               = '0;
    delay_ext[DELAY_W-1:0]  = delay;
    status                  = '0;
    status[1:0]             = state;
    status[STAT_KEY_ERR]    = key_err;
    status[STAT_WDT_EN]     = wdt_en;
    status[STAT_WDT_FIRED]  = wdt_fired;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rdata <= '0;
    else if (re) begin
      case (addr)
        ADDR_DELAY:    rdata <= delay_ext;
        ADDR_STATUS:   rdata <= status;
`ifdef BOA_PMU_WDT_EN
        ADDR_WDT_LOAD: rdata <= wdt_load;
`endif
        default:       rdata <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_boa_pmu.sv
// Directed bench for boa_pmu: delay timing, abort, key errors, async reset, watchdog.
module tb_boa_pmu;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        we = 1'b0, re = 1'b0;
  logic [2:0]  addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        ready, pmu_rst, pmu_shdn;

  int n_chk = 0;
  int n_err = 0;

  boa_pmu dut (
    .clk(clk), .rst(rst), .we(we), .re(re), .addr(addr), .wdata(wdata),
    .rdata(rdata), .ready(ready), .pmu_rst(pmu_rst), .pmu_shdn(pmu_shdn)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk); we = 1'b1; addr = a; wdata = d;
    @(posedge clk); #1; we = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a, output logic [31:0] d);
    @(negedge clk); re = 1'b1; addr = a;
    @(posedge clk); #1; re = 1'b0; d = rdata;
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
  endtask

  // Wait n edges; report whether either output rose at any point.
  task automatic quiet(input int n, input string tag);
    logic seen;
    seen = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
      seen = seen | pmu_rst | pmu_shdn;
    end
    chk(tag, {31'b0, seen}, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] v;

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pmu_rst", {31'b0, pmu_rst}, 0);
    chk("rst_pmu_shdn", {31'b0, pmu_shdn}, 0);
    chk("rst_rdata", rdata, 0);
    chk("ready", {31'b0, ready}, 1);
    @(negedge clk); rst = 1'b0;
    rd(3'd2, v); chk("rst_status", v, 0);
    rd(3'd1, v); chk("rst_delay", v, 0);

    // reset command, DELAY=0: output two edges after the write edge
    wr(3'd0, 32'h5AFE0001);
    @(posedge clk); #1; chk("d0_rst_early", {31'b0, pmu_rst}, 0);
    @(posedge clk); #1; chk("d0_rst_high", {31'b0, pmu_rst}, 1);
    chk("d0_shdn_low", {31'b0, pmu_shdn}, 0);
    rd(3'd2, v); chk("d0_status", v, 32'd2);
    quiet(0, "noop");

    // shutdown with DELAY=10: shdn exactly 12 edges after write
    do_reset();
    wr(3'd1, 32'd10);
    rd(3'd1, v); chk("delay_rb", v, 32'd10);
    wr(3'd0, 32'h5AFE0002);
    quiet(11, "d10_early");
    @(posedge clk); #1;
    chk("d10_shdn_high", {31'b0, pmu_shdn}, 1);
    chk("d10_rst_low", {31'b0, pmu_rst}, 0);
    rd(3'd2, v); chk("d10_status", v, 32'd3);

    // abort after 20 cycles of a 100-cycle count
    do_reset();
    wr(3'd1, 32'd100);
    wr(3'd0, 32'h5AFE0001);
    repeat (20) @(posedge clk);
    wr(3'd0, 32'h5AFE0000);
    rd(3'd2, v); chk("abort_status", v, 0);
    quiet(150, "abort_quiet");

    // first request wins; DELAY write mid-count does not disturb it
    do_reset();
    wr(3'd1, 32'd5);
    wr(3'd0, 32'h5AFE0002);
    wr(3'd0, 32'h5AFE0001);
    wr(3'd1, 32'd50);
    quiet(4, "first_wins_early");
    @(posedge clk); #1;
    chk("first_wins_shdn", {31'b0, pmu_shdn}, 1);
    chk("first_wins_rst", {31'b0, pmu_rst}, 0);
    rd(3'd1, v); chk("delay_next", v, 32'd50);

    // key error handling
    do_reset();
    wr(3'd0, 32'h5AFE0000);
    rd(3'd2, v); chk("idle_abort_noerr", v, 0);
    wr(3'd0, 32'h12340001);
    rd(3'd2, v); chk("badkey_status", v, 32'd4);
    quiet(10, "badkey_quiet");
    wr(3'd0, 32'h5AFE0001);
    repeat (3) @(posedge clk);
    rd(3'd2, v); chk("badkey_sticky", v, 32'd6);
    do_reset();
    rd(3'd2, v); chk("badkey_cleared", v, 0);

    // unmapped addresses, read hold, DELAY zero-extension
    wr(3'd5, 32'hFFFFFFFF);
    rd(3'd5, v); chk("addr5", v, 0);
    rd(3'd7, v); chk("addr7", v, 0);
    rd(3'd0, v); chk("ctrl_wo", v, 0);
    wr(3'd1, 32'hFFFFFFFF);
    rd(3'd1, v); chk("delay_zext", v, 32'h0000FFFF);
    wr(3'd1, 32'd7);
    repeat (2) @(posedge clk);
    #1; chk("rdata_hold", rdata, 32'h0000FFFF);

`ifdef BOA_PMU_WDT_EN
    do_reset();
    wr(3'd3, 32'd50);
    rd(3'd3, v); chk("wdt_load_rb", v, 32'd50);
    wr(3'd0, 32'h5AFE0003);
    rd(3'd2, v); chk("wdt_en_status", v, 32'd8);
    for (int k = 0; k < 12; k++) begin
      wr(3'd4, 32'h5AFE0000);
      if (k < 11) quiet(39, "wdt_kicked");
    end
    quiet(51, "wdt_expire_early");
    @(posedge clk); #1;
    chk("wdt_rst_high", {31'b0, pmu_rst}, 1);
    rd(3'd2, v); chk("wdt_fired_status", v, 32'd26);
`else
    do_reset();
    wr(3'd0, 32'h5AFE0003);
    rd(3'd2, v); chk("cmd11_invalid", v, 32'd4);
    wr(3'd3, 32'd50);
    rd(3'd3, v); chk("wdt_load_absent", v, 0);
    quiet(60, "cmd11_quiet");
`endif

    // async reset in COUNT with 5 cycles to go
    do_reset();
    wr(3'd1, 32'd20);
    wr(3'd0, 32'h5AFE0001);
    repeat (16) @(posedge clk);
    #3; rst = 1'b1;
    #1;
    chk("midrst_rst", {31'b0, pmu_rst}, 0);
    chk("midrst_rdata", rdata, 0);
    @(negedge clk); rst = 1'b0;
    quiet(40, "midrst_quiet");
    rd(3'd2, v); chk("midrst_status", v, 0);
    rd(3'd1, v); chk("midrst_delay", v, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
